vx_radix2_div: RTL and testbench
================================

# VX_radix2_div

Iterative radix-2 restoring integer divider, the inverse of the team's combinational Wallace multiplier. It takes an N-bit dividend and divisor over a valid/ready handshake and produces quotient and remainder after N iteration cycles. It sits beside the multiplier in the ALU/MulDiv path, serving DIV/DIVU/REM/REMU. It handles signed operands, divide-by-zero and signed overflow with RISC-V semantics.

## Interface
- N, 32: operand width in bits (≥ 2).
- TAGW, 1: width of the opaque tag carried with each operation (≥ 1).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider can accept; high only in IDLE.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_dividend  input  N  dividend.
- in_divisor  input  N  divisor.
- in_tag  input  TAGW  tag, returned unchanged with the result.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- out_quotient  output  N  quotient.
- out_remainder  output  N  remainder.
- out_tag  output  TAGW  tag of the completed operation.

## Operation
- States:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) captures the operands, tag and signedness, then branches:
    - divisor==0 → FIXUP with q=all-ones, r=dividend.
    - signed, dividend==2^(N-1) and divisor==all-ones → FIXUP with q=2^(N-1), r=0.
    - otherwise → BUSY; cnt=N; load |dividend| and |divisor| (absolute value only when in_signed); partial remainder=0.
  - BUSY: one iteration per cycle.
    - Shift {rem,quo} left 1, then compute t = rem − divisor with an (N+1)-bit subtract.
    - If t is non-negative, rem=t and quo[0]=1; else quo[0]=0.
    - Decrement cnt; after the iteration where cnt reaches 1 → FIXUP.
  - FIXUP: one cycle.
    - Negate q if signed and the operand signs differ.
    - Negate r if signed and the dividend was negative.
    - Skip both negations for the special cases, whose values are already final.
    - Register the results → DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready → IDLE.
- No overlap: a new request is never accepted while a result is pending or in progress.
- Invariant: dividend == q·divisor + r, with |r| < |divisor| and sign(r) == sign(dividend) or r==0. Exempt: divide-by-zero and overflow.
- Asynchronous reset, including mid-operation, forces:
  - state=IDLE, in_ready=1, out_valid=0.
  - out_quotient, out_remainder and out_tag = 0; cnt=0.
  - The in-flight operation is discarded.

## Timing
- Handshake at edge E0.
- Normal path:
  - Iterations occur at edges E1..EN.
  - FIXUP registers at edge EN+1.
  - out_valid is high from after EN+1, so latency is N+1 cycles.
- Special cases: FIXUP at E1, out_valid from after E2 (latency 2).
- Result handshake at edge Ek returns to IDLE. in_ready is high in the following cycle, so there is no same-cycle turnaround.
- Peak throughput: one operation per N+3 cycles (normal), 4 cycles (special case).
- While out_valid & !out_ready, all out_* signals are stable.
- in_* inputs are sampled only at the handshake edge and may change freely afterwards.

## Structure
- The state enum (IDLE/BUSY/FIXUP/DONE) is local to the module. No shared package additions are needed.
- Sub-module: VX_ks_adder, instantiated at N+1 bits with cin=1 and an inverted divisor for the iteration subtract. The same instance performs the FIXUP negations via operand muxing.
- Negation helper: an inline function (~x + 1) for the operand absolute value.
- Counter width is $clog2(N+1).

## Test plan
- N=32 unsigned, 100 / 7, tag=1 → q=14, r=2, out_tag=1. out_valid rises exactly 33 cycles after the accept edge.
- Signed −7 / 2 (0xFFFFFFF9 / 2) → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Signed 7 / −2 → q=−3, r=1.
- Divide by zero:
  - 5 / 0, unsigned or signed → q=0xFFFFFFFF, r=5, latency 2.
  - 0 / 0 → q=0xFFFFFFFF, r=0.
- Signed overflow: 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, latency 2. The same operands unsigned → q=0, r=0x80000000 after 33 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Outputs stay stable, in_ready stays 0, and in_valid pulses are ignored.
  - Release out_ready → in_ready=1 in the next cycle.
- Reset mid-operation: assert reset during BUSY iteration 5, asynchronously between edges.
  - out_valid=0 and in_ready=1 immediately.
  - After deassertion, a new 9 / 3 returns q=3, r=0 with normal latency.

Source files
------------

// File: rtl/vx_radix2_div_pkg.sv
// vx_radix2_div_pkg
// Shared definitions for the radix-2 restoring divider slice.
//   - default operand and tag widths used by the interface and the top
//   - sign-rule helpers that decide when quotient / remainder are negated
package vx_radix2_div_pkg;

  localparam int DIV_N_DEFAULT    = 32;
  localparam int DIV_TAGW_DEFAULT = 1;

  // The quotient is negative when signed operands have opposite signs.
  function automatic logic quo_sign(input logic is_signed,
                                    input logic dividend_msb,
                                    input logic divisor_msb);
    return is_signed & (dividend_msb ^ divisor_msb);
  endfunction

  // The remainder takes the sign of the dividend.
  function automatic logic rem_sign(input logic is_signed,
                                    input logic dividend_msb);
    return is_signed & dividend_msb;
  endfunction

endpackage

// File: rtl/vx_radix2_div_if.sv
// vx_radix2_div_if
// Request/response bundle of the divider.
//   request : in_valid, in_ready, in_signed, in_dividend, in_divisor, in_tag
//   response: out_valid, out_ready, out_quotient, out_remainder, out_tag
// Modports:
//   master - the requester / result consumer (ALU side)
//   slave  - the divider itself
interface vx_radix2_div_if
  import vx_radix2_div_pkg::*;
#(
  parameter int N    = DIV_N_DEFAULT,
  parameter int TAGW = DIV_TAGW_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic            in_signed;
  logic [N-1:0]    in_dividend;
  logic [N-1:0]    in_divisor;
  logic [TAGW-1:0] in_tag;

  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_quotient;
  logic [N-1:0]    out_remainder;
  logic [TAGW-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, in_tag, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_tag
  );

endinterface

// File: rtl/vx_radix2_div_ks_adder.sv
// vx_radix2_div_ks_adder
// Kogge-Stone parallel-prefix adder, sum = a + b + cin (carry-out dropped).
// Ports:
//   a, b : W-bit operands
//   cin  : carry into bit 0
//   sum  : W-bit result
module vx_radix2_div_ks_adder #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] prop0;
  logic [W-1:0] gen_pfx;
  logic [W-1:0] prop_pfx;
  logic [W-1:0] gen_nxt;
  logic [W-1:0] prop_nxt;
  logic [W-1:0] carry;

  // gen_pfx[i] / prop_pfx[i] end up as group generate / propagate of
  // bits [i:0]; each pass doubles the span covered by every prefix.
  always_comb begin
    prop0    = a ^ b;
    gen_pfx  = a & b;
    prop_pfx = prop0;
    gen_nxt  = '0;
    prop_nxt = '0;
    for (int d = 1; d < W; d = d * 2) begin
      gen_nxt  = gen_pfx;
      prop_nxt = prop_pfx;
      for (int i = d; i < W; i++) begin
        gen_nxt[i]  = gen_pfx[i] | (prop_pfx[i] & gen_pfx[i-d]);
        prop_nxt[i] = prop_pfx[i] & prop_pfx[i-d];
      end
      gen_pfx  = gen_nxt;
      prop_pfx = prop_nxt;
    end
    // cin folds in as a generate sitting just below bit 0.
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i < W; i++) begin
      carry[i] = gen_pfx[i-1] | (prop_pfx[i-1] & cin);
    end
    sum = prop0 ^ carry;
  end

endmodule

// File: rtl/vx_radix2_div.sv
// vx_radix2_div
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, RISC-V
// semantics for divide-by-zero and signed overflow.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : vx_radix2_div_if.slave (valid/ready request and response)
// Latency: N+1 cycles from the accept edge for normal operations,
// 2 cycles for divide-by-zero and signed overflow.
module vx_radix2_div
  import vx_radix2_div_pkg::*;
#(
  parameter int N    = DIV_N_DEFAULT,
  parameter int TAGW = DIV_TAGW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  vx_radix2_div_if.slave bus
);

  localparam int            CW      = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  MIN_N   = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    rem;
  logic [N-1:0]    quo;
  logic [N-1:0]    dvs;
  logic            neg_q;
  logic            neg_r;
  logic            hold;
  logic [TAGW-1:0] tag_q;
  logic [N-1:0]    out_q;
  logic [N-1:0]    out_r;
  logic [TAGW-1:0] out_t;

  logic            div_zero;
  logic            overflow;
  logic [N:0]      shifted;
  logic [N:0]      add_a;
  logic [N:0]      add_b;
  logic [N:0]      add_sum;

  function automatic logic [N-1:0] neg(input logic [N-1:0] x);
    return ~x + ONE_N;
  endfunction

  function automatic logic [N-1:0] abs_val(input logic is_signed,
                                           input logic [N-1:0] x);
    return (is_signed && x[N-1]) ? neg(x) : x;
  endfunction

  assign div_zero = (bus.in_divisor == '0);
  assign overflow = bus.in_signed && (bus.in_dividend == MIN_N) &&
                    (bus.in_divisor == '1);

  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.out_quotient  = out_q;
  assign bus.out_remainder = out_r;
  assign bus.out_tag       = out_t;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Special cases also pass through BUSY for a single held cycle (cnt=1),
  // which gives them their two-cycle latency without a fifth state.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)       next_state = BUSY;
      BUSY:    if (cnt == CNT_ONE)     next_state = FIXUP;
      FIXUP:                           next_state = DONE;
      DONE:    if (bus.out_ready)      next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // One adder serves both phases: rem - divisor while iterating, and
  // ~quo + 1 for the quotient negation in FIXUP.
  always_comb begin
    shifted = {rem, quo[N-1]};
    add_a   = shifted;
    add_b   = ~{1'b0, dvs};
    if (state == FIXUP) begin
      add_a = '0;
      add_b = {1'b1, ~quo};
    end
  end

  vx_radix2_div_ks_adder #(.W(N + 1)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b1),
    .sum (add_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hold  <= 1'b0;
      tag_q <= '0;
      out_q <= '0;
      out_r <= '0;
      out_t <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            tag_q <= bus.in_tag;
            dvs   <= abs_val(bus.in_signed, bus.in_divisor);
            if (div_zero || overflow) begin
              cnt   <= CNT_ONE;
              hold  <= 1'b1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              quo   <= div_zero ? '1 : MIN_N;
              rem   <= div_zero ? bus.in_dividend : '0;
            end else begin
              cnt   <= CNT_N;
              hold  <= 1'b0;
              neg_q <= quo_sign(bus.in_signed, bus.in_dividend[N-1],
                                bus.in_divisor[N-1]);
              neg_r <= rem_sign(bus.in_signed, bus.in_dividend[N-1]);
              quo   <= abs_val(bus.in_signed, bus.in_dividend);
              rem   <= '0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (!hold) begin
            // add_sum[N] set means the trial subtract went negative: restore.
            rem <= add_sum[N] ? shifted[N-1:0] : add_sum[N-1:0];
            quo <= {quo[N-2:0], ~add_sum[N]};
          end
        end
        FIXUP: begin
          out_q <= neg_q ? add_sum[N-1:0] : quo;
          out_r <= neg_r ? neg(rem) : rem;
          out_t <= tag_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_radix2_div.sv
// tb_vx_radix2_div
// Self-checking bench for vx_radix2_div at N=32, TAGW=1: directed corner
// cases, backpressure, mid-operation reset and randomized operations
// compared against an arithmetic reference model.
module tb_vx_radix2_div;

  localparam int N    = 32;
  localparam int TAGW = 1;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vx_radix2_div_if #(.N(N), .TAGW(TAGW)) bus ();

  vx_radix2_div #(.N(N), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: RISC-V division rules expressed with plain arithmetic.
  task automatic refModel(input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] q,
                          output logic [31:0] r, output int lat);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 2;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 2;
    end else if (sgn) begin
      q = 32'(sa / sb); r = 32'(sa % sb); lat = N + 1;
    end else begin
      q = a / b; r = a % b; lat = N + 1;
    end
  endtask

  task automatic scrambleInputs();
    bus.in_dividend = $urandom;
    bus.in_divisor  = $urandom;
    bus.in_signed   = 1'($urandom_range(0, 1));
    bus.in_tag      = TAGW'($urandom);
  endtask

  task automatic applyStimulus(input string name, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [TAGW-1:0] tag,
                               input bit backpressure);
    logic [31:0] eq;
    logic [31:0] er;
    int          elat;
    int          lat;
    refModel(sgn, a, b, eq, er, elat);
    @(negedge clk);
    checkOutput({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid    = 1'b1;
    bus.in_signed   = sgn;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_tag      = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scrambleInputs();
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({name, "_latency"}, 64'(lat), 64'(elat));
    checkOutput({name, "_q"}, 64'(bus.out_quotient), 64'(eq));
    checkOutput({name, "_r"}, 64'(bus.out_remainder), 64'(er));
    checkOutput({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
    if (backpressure) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.in_valid = 1'($urandom_range(0, 1));
        scrambleInputs();
        @(posedge clk);
        #1;
        checkOutput({name, "_bp_valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({name, "_bp_in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({name, "_bp_q"}, 64'(bus.out_quotient), 64'(eq));
        checkOutput({name, "_bp_r"}, 64'(bus.out_remainder), 64'(er));
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({name, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({name, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    int          sel;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scrambleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_q", 64'(bus.out_quotient), 64'd0);
    checkOutput("reset_r", 64'(bus.out_remainder), 64'd0);
    checkOutput("reset_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("u100_7", 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    applyStimulus("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    applyStimulus("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    applyStimulus("u_div0", 1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
    applyStimulus("s_div0", 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
    applyStimulus("zero_zero", 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus("u_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("s_min_2", 1'b1, 32'h8000_0000, 32'd2, 1'b0, 1'b0);
    applyStimulus("backpressure", 1'b1, 32'd12345, 32'hFFFF_FFEF, 1'b1, 1'b1);

    // Reset asserted between edges during the fifth iteration.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_signed   = 1'b0;
    bus.in_dividend = 32'd1000;
    bus.in_divisor  = 32'd3;
    bus.in_tag      = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midreset_q", 64'(bus.out_quotient), 64'd0);
    checkOutput("midreset_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("after_reset_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rs  = 1'($urandom_range(0, 1));
      ra  = $urandom;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       rb = 32'd0;
        1:       begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'($urandom_range(0, 1) == 1 ? -32'sd3 : 32'sd3);
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      applyStimulus("random", rs, ra, rb, TAGW'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
